// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad reader with press/release debounce and a
// valid/ack output handshake.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   rows_n     keypad rows, active-low, asynchronous to clk
//   key_ack    consumer acknowledge, only meaningful while key_valid=1
//   cols_n     column drive, active-low one-cold
//   key_code   encoded key of the last accepted press
//   key_valid  key_code holds a key not yet acknowledged
module keypad_scanner #(
  parameter int SCAN_TICKS     = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  input  logic       key_ack,
  output logic [3:0] cols_n,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int TW = $clog2(SCAN_TICKS + 1);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  // Indexed by {row, col}; entry 0 is row0/col0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {SCAN, PRESS_DB, WAIT_REL} state_t;

  state_t        state;
  logic [3:0]    rows_m, rows_s;
  logic [TW-1:0] tick_cnt;
  logic [1:0]    col, cap_row, pick_row;
  logic [DW-1:0] db_cnt, db_nxt;
  logic          tick, row_hit, cap_low, db_done, accept;

  // Two-flop synchronizer; idle (released) rows read as 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_m <= 4'b1111;
      rows_s <= 4'b1111;
    end else begin
      rows_m <= rows_n;
      rows_s <= rows_m;
    end
  end

  // Free-running dwell counter, independent of FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TW'(SCAN_TICKS));

  // Lowest-index low row wins when several keys share the column.
  always_comb begin
    pick_row = 2'd3;
    if      (!rows_s[0]) pick_row = 2'd0;
    else if (!rows_s[1]) pick_row = 2'd1;
    else if (!rows_s[2]) pick_row = 2'd2;
  end

  assign row_hit = (rows_s != 4'b1111);
  assign cap_low = !rows_s[cap_row];
  assign db_nxt  = db_cnt + 1'b1;
  assign db_done = (db_nxt == DW'(DEBOUNCE_SCANS));
  assign accept  = tick && (state == PRESS_DB) && cap_low && db_done;

  // cols_n is kept as its own rotating register so the pins never glitch
  // through a decode of col.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      cols_n    <= 4'b1110;
      cap_row   <= 2'd0;
      db_cnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      // An accepted press is dropped if the previous key is still pending;
      // the FSM still goes to WAIT_REL so the press is never re-reported.
      if (accept && (!key_valid || key_ack)) begin
        key_code  <= KEY_MAP[{cap_row, col}];
        key_valid <= 1'b1;
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end

      if (tick) begin
        case (state)
          SCAN: begin
            if (row_hit) begin
              cap_row <= pick_row;
              db_cnt  <= '0;
              state   <= PRESS_DB;
            end else begin
              col    <= col + 2'd1;
              cols_n <= {cols_n[2:0], cols_n[3]};
            end
          end
          PRESS_DB: begin
            if (cap_low) begin
              if (db_done) begin
                db_cnt <= '0;
                state  <= WAIT_REL;
              end else begin
                db_cnt <= db_nxt;
              end
            end else begin
              state  <= SCAN;
              col    <= col + 2'd1;
              cols_n <= {cols_n[2:0], cols_n[3]};
            end
          end
          WAIT_REL: begin
            if (!cap_low) begin
              if (db_done) begin
                db_cnt <= '0;
                state  <= SCAN;
                col    <= col + 2'd1;
                cols_n <= {cols_n[2:0], cols_n[3]};
              end else begin
                db_cnt <= db_nxt;
              end
            end else begin
              db_cnt <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_TICKS=3, DEBOUNCE_SCANS=2, so one
// dwell is 4 cycles). A keypad model drives rows_n from the pressed-key
// matrix and cols_n; expected key codes go into a queue when a press that
// should be reported is driven and are popped when the bench acknowledges.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows_n;
  logic       key_ack = 1'b0;
  logic [3:0] cols_n, key_code;
  logic       key_valid;

  logic [3:0][3:0] press = '0;   // press[row][col]
  logic [3:0]      exp_q[$];
  logic [3:0]      exp_v;
  int tests = 0, fails = 0, rises = 0;
  logic kv_q = 1'b0;

  keypad_scanner #(.SCAN_TICKS(3), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .rows_n(rows_n), .key_ack(key_ack),
    .cols_n(cols_n), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r][c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid && !kv_q) rises++;
    kv_q = key_valid;
  end

  function automatic logic [3:0] col_n(input int c);
    logic [3:0] one;
    one = 4'b0001 << c;
    return ~one;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after cols_n switches to column c.
  task automatic wait_col_start(input int c);
    int n;
    n = 0;
    while (cols_n == col_n(c) && n < 200) begin @(negedge clk); n++; end
    while (cols_n != col_n(c) && n < 200) begin @(negedge clk); n++; end
    chk("col_start_timeout", 32'(n < 200), 1);
  endtask

  task automatic ack_key(input string tag);
    exp_v = exp_q.pop_front();
    chk(tag, key_code, exp_v);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    chk({tag, "_valid_clr"}, key_valid, 0);
  endtask

  initial begin
    int n;
    // Reset state
    step(3);
    chk("rst_cols", cols_n, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 4'h0);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      chk("scan_seq", cols_n, col_n((i / 4) % 4));
    end

    // Clean press of '5'
    wait_col_start(1);
    press[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    step(11);
    chk("p5_not_yet", key_valid, 0);
    step(1);
    chk("p5_valid", key_valid, 1);
    step(28);
    chk("p5_hold_valid", key_valid, 1);
    chk("p5_hold_code", key_code, exp_q[0]);
    press[1][1] = 1'b0;
    step(3);
    ack_key("p5_code");
    step(40);
    chk("p5_single", key_valid, 0);

    // One-tick glitch: detected, then rejected by the press debounce
    wait_col_start(1);
    press[1][1] = 1'b1;
    step(4);
    press[1][1] = 1'b0;
    chk("bounce_detect_hold", cols_n, 4'b1101);
    step(4);
    chk("bounce_back_scan", cols_n, 4'b1011);
    step(30);
    chk("bounce_no_key", key_valid, 0);

    // Glitch narrower than the synchronizer window before a tick
    wait_col_start(1);
    step(2);
    press[1][1] = 1'b1;
    step(1);
    press[1][1] = 1'b0;
    step(1);
    chk("short_glitch_ignored", cols_n, 4'b1011);
    step(30);
    chk("short_glitch_no_key", key_valid, 0);

    // Overrun: '9' pending, '#' discarded
    wait_col_start(2);
    press[2][2] = 1'b1;
    exp_q.push_back(4'h9);
    step(12);
    chk("p9_valid", key_valid, 1);
    step(4);
    press[2][2] = 1'b0;
    wait_col_start(2);
    press[3][2] = 1'b1;
    step(13);
    chk("ovr_code_kept", key_code, 4'h9);
    chk("ovr_valid", key_valid, 1);
    step(4);
    press[3][2] = 1'b0;

    // '#' accepted in the same cycle as the ack of '9'
    wait_col_start(2);
    press[3][2] = 1'b1;
    exp_q.push_back(4'hF);
    step(11);
    exp_v = exp_q.pop_front();
    chk("p9_code", key_code, exp_v);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    chk("same_cyc_valid", key_valid, 1);
    chk("same_cyc_code", key_code, exp_q[0]);
    step(4);
    press[3][2] = 1'b0;
    ack_key("pF_code");

    // Multi-key on col0: row1 beats row3
    wait_col_start(0);
    press[1][0] = 1'b1;
    press[3][0] = 1'b1;
    exp_q.push_back(4'h4);
    step(12);
    chk("multi_valid", key_valid, 1);
    ack_key("multi_code");
    press[3][0] = 1'b0;
    step(20);
    chk("multi_still_wait", cols_n, 4'b1110);
    press[1][0] = 1'b0;
    n = 0;
    while (cols_n == 4'b1110 && n < 40) begin step(1); n++; end
    chk("multi_release_timeout", 32'(n < 40), 1);

    // Asynchronous reset in PRESS_DB
    wait_col_start(1);
    press[1][1] = 1'b1;
    step(6);
    #1 reset = 1'b1;
    #1;
    chk("arst_cols", cols_n, 4'b1110);
    chk("arst_valid", key_valid, 0);
    chk("arst_code", key_code, 4'h0);
    step(3);
    press[1][1] = 1'b0;
    reset = 1'b0;
    step(3);
    chk("arst_tick_restart0", cols_n, 4'b1110);
    step(1);
    chk("arst_tick_restart1", cols_n, 4'b1101);
    step(40);
    chk("arst_no_key", key_valid, 0);

    chk("key_count", rises, 3);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad reader for the multiplier's operand entry path. It sits at the input end of the board, opposite the display multiplexer. It drives one active-low column of a 4x4 keypad at a time and samples the active-low rows through a synchronizer. Each key goes through press and release debounce, and the block presents one 4-bit key code per physical press to downstream logic with a valid/ack handshake.

## Interface
- SCAN_TICKS, default 10000: dwell length per column is SCAN_TICKS+1 clk cycles; legal range ≥ 3.
- DEBOUNCE_SCANS, default 4: consecutive confirming samples required for both press and release; legal range ≥ 1.
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- rows_n  input  4  keypad rows, active-low; external pull-ups; asynchronous to clk.
- key_ack  input  1  consumer acknowledge; sampled only while key_valid=1.
- cols_n  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  encoded key, registered.
- key_valid  output  1  key_code holds an unconsumed key.

## Operation
- Sync: rows_n passes through a 2-flop synchronizer to give rows_s. Only rows_s is used by the logic.
- Tick: a free-running counter runs 0..SCAN_TICKS and wraps. The tick is the cycle where the count equals SCAN_TICKS. The counter is never gated by FSM state.
- Column select col runs 0..3, with cols_n = ~(1<<col). In SCAN only, col advances at each tick and wraps from 3 to 0. In all other states col is frozen.
- Row pick: if several rows_s bits are low, the lowest-index row wins.
- Key map is code = f(row, col):
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E(*), 0, F(#), D
- FSM states: SCAN, PRESS_DB, WAIT_REL. All transitions are evaluated only on a tick.
  - SCAN: if any rows_s bit is low, capture that row and the current col, clear the debounce count, go to PRESS_DB, and do not advance col. Otherwise advance col.
  - PRESS_DB: if the captured row is low, count += 1. If the captured row is high, go to SCAN and advance col.
  - PRESS_DB, when count reaches DEBOUNCE_SCANS: the key is accepted. Go to WAIT_REL with the count cleared.
  - WAIT_REL: if the captured row is high, count += 1. If it is low, clear the count. When count reaches DEBOUNCE_SCANS, go to SCAN; col advances on that same tick.
- On acceptance, key_code is loaded and key_valid is set only if key_valid=0 or key_ack=1 in that cycle. Otherwise the press is discarded, and the FSM still enters WAIT_REL, so one press never produces two keys.
- Handshake: key_valid stays high and key_code stays stable until a cycle with key_ack=1. key_valid clears on the next edge. key_ack while key_valid=0 is ignored.
- Simultaneous acceptance and key_ack: the new key loads and key_valid stays 1.
- Only the captured row is checked in PRESS_DB and WAIT_REL. Other keys pressed during this time are ignored.

## Timing
- Reset values:
  - cols_n = 4'b1110
  - key_code = 4'h0
  - key_valid = 0
  - state = SCAN, counters = 0, synchronizer = 4'b1111
- Reset mid-debounce or with key_valid high drops the key with no output pulse. After release of reset, the tick counter restarts from 0.
- A row change at the pins is visible to the FSM 2 edges later. It must be stable ≥ 2 cycles before a tick to be sampled on that tick.
- Press latency: key_valid rises on the edge of the tick DEBOUNCE_SCANS dwells after the detecting tick. That is DEBOUNCE_SCANS×(SCAN_TICKS+1) cycles after detection.
- Release: the earliest next detection is one tick after leaving WAIT_REL.
- Worst-case detect delay from a stable press is 4 dwells plus 2 cycles.

## Test plan
Run with SCAN_TICKS=3 and DEBOUNCE_SCANS=2 unless stated.
- Reset and scan:
  - During reset, cols_n=1110, key_valid=0, key_code=0.
  - After release, cols_n steps 1110→1101→1011→0111→1110, changing every 4 cycles.
- Clean press of '5' (row1/col1), held 40 cycles then released:
  - key_valid rises 8 cycles after the detecting tick, with key_code=4'h5.
  - Stays high until key_ack; clears one cycle after the ack.
  - Exactly one key is reported.
- Bounce: row1 low for one tick only (glitch while col1 is driven):
  - FSM returns to SCAN and no key_valid.
  - A glitch shorter than 2 cycles before the tick is never detected.
- Overrun: press '9' and do not ack, then press '#':
  - key_code stays 4'h9.
  - A '#' press accepted in the same cycle as key_ack yields key_code=4'hF and key_valid stays 1.
- Multi-key: rows 1 and 3 are low on col0.
  - key_code=4'h4.
  - A release of row3 while row1 is held does not end WAIT_REL.
- Async reset asserted mid-PRESS_DB: all outputs are at reset values within the same cycle, and no key is reported afterwards.
